// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the LCD frame scheduler.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        LINE_ADDR,
        CHAR_FETCH,
        CHAR_WRITE,
        FRAME_END
    } state_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_SETUP,
        P_PULSE,
        P_WAIT
    } phy_state_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE0    = 8'h80;
    localparam logic [7:0] CMD_LINE1    = 8'hC0;

    // Mode blocks register their char one cycle after index changes.
    localparam int unsigned FETCH_CYC = 2;

    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_ENTRY;
            default: return CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_frame_scheduler_if.sv
// HD44780 parallel bus driven by the frame scheduler.
interface lcd_frame_scheduler_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    modport master (output lcd_e, output lcd_rs, output lcd_rw, output lcd_data);
    modport slave  (input  lcd_e, input  lcd_rs, input  lcd_rw, input  lcd_data);
endinterface

// File: rtl/lcd_write_phy.sv
// Single-byte HD44780 write strobe: setup, E pulse, post-write wait, then done.
module lcd_write_phy
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC     = 3,
    parameter int unsigned E_PW_CYC      = 25,
    parameter int unsigned CHAR_WAIT_CYC = 2500,
    parameter int unsigned CLR_WAIT_CYC  = 100000,
    parameter int unsigned CNT_W         = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] wr_byte,
    input  logic       wr_rs,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       done
);

    phy_state_t       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= P_IDLE;
            cnt      <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                P_IDLE: begin
                    if (start) begin
                        lcd_data <= wr_byte;
                        lcd_rs   <= wr_rs;
                        cnt      <= CNT_W'(SETUP_CYC - 1);
                        state    <= P_SETUP;
                    end
                end
                P_SETUP: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b1;
                        cnt   <= CNT_W'(E_PW_CYC - 1);
                        state <= P_PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                P_PULSE: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b0;
                        // Clear-display needs the long execution wait.
                        cnt   <= (!lcd_rs && lcd_data == CMD_CLEAR) ? CNT_W'(CLR_WAIT_CYC - 1)
                                                                   : CNT_W'(CHAR_WAIT_CYC - 1);
                        state <= P_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                P_WAIT: begin
                    if (cnt == '0) begin
                        done  <= 1'b1;
                        state <= P_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= P_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Refreshes a 2x16 HD44780 display from one of four mode blocks, frame after frame.
module lcd_frame_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned PWRUP_CYC     = 750000,
    parameter int unsigned E_PW_CYC      = 25,
    parameter int unsigned SETUP_CYC     = 3,
    parameter int unsigned CHAR_WAIT_CYC = 2500,
    parameter int unsigned CLR_WAIT_CYC  = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode_sel,
    input  logic [7:0]             char_clk,
    input  logic [7:0]             char_stop,
    input  logic [7:0]             char_alarm,
    input  logic [7:0]             char_set,
    output logic [4:0]             index,
    output logic                   frame_done,
    lcd_frame_scheduler_if.master  lcd
);

    localparam int unsigned MAX_CYC = max_of(max_of(max_of(PWRUP_CYC, E_PW_CYC),
                                                    max_of(SETUP_CYC, CHAR_WAIT_CYC)),
                                             CLR_WAIT_CYC);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       init_idx;
    logic [1:0]       mode_q;
    logic             issued;
    logic             wr_start;
    logic             wr_rs;
    logic [7:0]       wr_byte;
    logic             wr_done;
    logic [7:0]       char_sel;
    logic             phy_e;
    logic             phy_rs;
    logic [7:0]       phy_data;

    always_comb begin
        char_sel = char_clk;
        case (mode_q)
            2'd0:    char_sel = char_clk;
            2'd1:    char_sel = char_stop;
            2'd2:    char_sel = char_alarm;
            default: char_sel = char_set;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= PWR_WAIT;
            cnt        <= '0;
            init_idx   <= '0;
            mode_q     <= '0;
            index      <= '0;
            issued     <= 1'b0;
            wr_start   <= 1'b0;
            wr_rs      <= 1'b0;
            wr_byte    <= '0;
            frame_done <= 1'b0;
        end else begin
            wr_start   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                PWR_WAIT: begin
                    if (cnt == CNT_W'(PWRUP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= INIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                INIT: begin
                    if (!issued) begin
                        wr_start <= 1'b1;
                        wr_byte  <= init_cmd(init_idx);
                        wr_rs    <= 1'b0;
                        issued   <= 1'b1;
                    end else if (wr_done) begin
                        issued <= 1'b0;
                        if (init_idx == 2'd3) begin
                            init_idx <= '0;
                            state    <= LINE_ADDR;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                        end
                    end
                end
                LINE_ADDR: begin
                    if (!issued) begin
                        // Mode is frozen for a whole frame at the line-0 address write.
                        if (index == 5'd0) mode_q <= mode_sel;
                        wr_start <= 1'b1;
                        wr_byte  <= index[4] ? CMD_LINE1 : CMD_LINE0;
                        wr_rs    <= 1'b0;
                        issued   <= 1'b1;
                    end else if (wr_done) begin
                        issued <= 1'b0;
                        cnt    <= '0;
                        state  <= CHAR_FETCH;
                    end
                end
                CHAR_FETCH: begin
                    if (cnt == CNT_W'(FETCH_CYC - 1)) begin
                        cnt     <= '0;
                        wr_byte <= char_sel;
                        wr_rs   <= 1'b1;
                        state   <= CHAR_WRITE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHAR_WRITE: begin
                    if (!issued) begin
                        wr_start <= 1'b1;
                        issued   <= 1'b1;
                    end else if (wr_done) begin
                        issued <= 1'b0;
                        if (index == 5'd31) begin
                            index      <= '0;
                            frame_done <= 1'b1;
                            state      <= FRAME_END;
                        end else begin
                            index <= index + 5'd1;
                            state <= (index == 5'd15) ? LINE_ADDR : CHAR_FETCH;
                        end
                    end
                end
                FRAME_END: state <= LINE_ADDR;
                default:   state <= PWR_WAIT;
            endcase
        end
    end

    lcd_write_phy #(
        .SETUP_CYC     (SETUP_CYC),
        .E_PW_CYC      (E_PW_CYC),
        .CHAR_WAIT_CYC (CHAR_WAIT_CYC),
        .CLR_WAIT_CYC  (CLR_WAIT_CYC),
        .CNT_W         (CNT_W)
    ) u_phy (
        .clk      (clk),
        .rst      (rst),
        .start    (wr_start),
        .wr_byte  (wr_byte),
        .wr_rs    (wr_rs),
        .lcd_e    (phy_e),
        .lcd_rs   (phy_rs),
        .lcd_data (phy_data),
        .done     (wr_done)
    );

    assign lcd.lcd_e    = phy_e;
    assign lcd.lcd_rs   = phy_rs;
    assign lcd.lcd_data = phy_data;
    assign lcd.lcd_rw   = 1'b0;

endmodule

// File: doc/lcd_frame_scheduler.md
LCD_FRAME_SCHEDULER -- requirements
Module: lcd_frame_scheduler

Interface
REQ-001 SHALL have parameter PWRUP_CYC, 750000, cycles waited after reset before the first command (15 ms at 50 MHz).
REQ-002 SHALL have parameter E_PW_CYC, 25, cycles lcd_e is held high per write.
REQ-003 SHALL have parameter SETUP_CYC, 3, cycles lcd_rs/lcd_data are stable before lcd_e rises.
REQ-004 SHALL have parameter CHAR_WAIT_CYC, 2500, cycles waited after lcd_e falls for a normal write.
REQ-005 SHALL have parameter CLR_WAIT_CYC, 100000, cycles waited after lcd_e falls for the clear command (0x01).
REQ-006 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port mode_sel  input  2  display source: 0 clock, 1 stopwatch, 2 alarm, 3 time-set.
REQ-009 SHALL have ports char_clk, char_stop, char_alarm, char_set  input  8 each  ASCII from each mode block for the current index.
REQ-010 SHALL have port index  output  5  character position 0..31 driven to all mode blocks.
REQ-011 SHALL have ports lcd_e, lcd_rs, lcd_rw  output  1 each  HD44780 strobe, register select (1 = data), read/write (tied 0).
REQ-012 SHALL have port lcd_data  output  8  HD44780 data bus.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after the write wait of index 31 completes.

Function
REQ-014 SHALL run FSM states PWR_WAIT, INIT, LINE_ADDR, CHAR_FETCH, CHAR_WRITE, FRAME_END.
REQ-015 SHALL stay in PWR_WAIT for exactly PWRUP_CYC cycles after reset release, then enter INIT.
REQ-016 SHALL in INIT issue commands 0x38, 0x0C, 0x06, 0x01 in order, with RS=0 and the wait after each per REQ-005/REQ-004.
REQ-017 SHALL issue each byte as a write: data/RS set -> SETUP_CYC cycles -> E high for E_PW_CYC cycles -> E low -> wait cycles; the next byte is not driven until the wait ends.
REQ-018 SHALL issue LINE_ADDR 0x80 (RS=0) before index 0 and 0xC0 (RS=0) before index 16.
REQ-019 SHALL in CHAR_FETCH drive index and wait 2 cycles before sampling the selected char (mode blocks register out one cycle after index).
REQ-020 SHALL write the sampled char with RS=1 in CHAR_WRITE, then increment index.
REQ-021 SHALL wrap index 31->0 through FRAME_END: pulse frame_done for one cycle, then go to LINE_ADDR (0x80); INIT is not repeated.
REQ-022 SHALL latch mode_sel only on entry to LINE_ADDR 0x80; a mode_sel change mid-frame takes effect from the next frame.
REQ-023 SHALL hold index stable from CHAR_FETCH until the end of that char's write wait.
REQ-024 SHALL size its single wait counter to the largest of the timing parameters, with no truncation.
REQ-025 SHALL keep lcd_rw at 0 at all times.

Reset
REQ-026 SHALL, while rst=0 at a clock edge, set state=PWR_WAIT, index=0, lcd_e=0, lcd_rs=0, lcd_data=0x00, frame_done=0, counter=0, latched mode=0.
REQ-027 SHALL on reset during a write force lcd_e low on the next edge and restart the full power-up/INIT sequence.

Structure
REQ-028 SHALL take the FSM state enum and the command constants (0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0) from the shared package lcd_pkg.
REQ-029 SHALL instantiate one sub-module, lcd_write_phy: a start/done byte-strobe generator that owns SETUP/E_PW/wait timing, with done one cycle after the wait ends.

Verification (PWRUP_CYC=20, E_PW_CYC=2, SETUP_CYC=1, CHAR_WAIT_CYC=4, CLR_WAIT_CYC=10)
REQ-030 SHALL cover power-up: release rst -> no lcd_e for 20 cycles; then E pulses carry 0x38, 0x0C, 0x06, 0x01 with RS=0; the 0x01 pulse is followed by a 10-cycle gap.
REQ-031 SHALL cover a full frame: mode_sel=1, char_stop=0x41+index -> bytes 0x80, 0x41..0x50, 0xC0, 0x51..0x60; frame_done pulses once.
REQ-032 SHALL cover mid-frame mode change: mode_sel 1->0 at index 5 -> remainder of frame from char_stop, next frame from char_clk.
REQ-033 SHALL cover write timing: each E high lasts exactly 2 cycles, and data/RS are stable from 1 cycle before E rise until E fall.
REQ-034 SHALL cover reset mid-write: rst=0 while lcd_e=1 -> lcd_e=0 next edge; after release, a 20-cycle quiet period, then 0x38.
REQ-035 SHALL cover wrap: after index 31 -> frame_done=1 for one cycle, then 0x80, then index=0 with no INIT bytes.
